// File: rtl/core_mem_responder_if.sv
// Memory bus between the 8-bit core / video scanner and core_mem_responder.
//   address/wdata/wren : CPU byte address, write data and write strobe
//   data               : CPU read data, one cycle after address
//   vid_addr/vid_req   : scanner offset into video RAM and read request
//   vid_data/vid_valid : scanner read data and its one-cycle valid pulse
//   rom_wr_err         : sticky flag for a CPU write into the boot ROM
interface core_mem_responder_if;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned VID_W  = 12;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              wren;
    logic [DATA_W-1:0] data;
    logic [VID_W-1:0]  vid_addr;
    logic              vid_req;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic              rom_wr_err;

    // Requester side: CPU and scanner.
    modport master (
        output address, wdata, wren, vid_addr, vid_req,
        input  data, vid_data, vid_valid, rom_wr_err
    );

    // Responder side.
    modport slave (
        input  address, wdata, wren, vid_addr, vid_req,
        output data, vid_data, vid_valid, rom_wr_err
    );
endinterface

// File: rtl/core_mem_responder.sv
// Bus responder for the 8-bit core: decodes the 20-bit byte address into RAM, text video RAM,
// boot ROM or unmapped space, serves CPU reads with one cycle of latency and commits writes.
// The video RAM has a single read port shared by the CPU and the video scanner; the CPU always
// wins and a blocked scanner request waits in PEND until the CPU leaves video RAM.
// Ports:
//   clock : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : core_mem_responder_if.slave (CPU bus, scanner port, rom_wr_err)
module core_mem_responder #(
    parameter int unsigned RAM_AW   = 16,
    parameter logic [19:0] VID_BASE = 20'hB8000,
    parameter logic [19:0] ROM_BASE = 20'hF0000,
    parameter logic [7:0]  UNMAP    = 8'hFF
) (
    input  logic                 clock,
    input  logic                 reset,
    core_mem_responder_if.slave  bus
);
    localparam int unsigned VID_AW    = 12;
    localparam int unsigned ROM_AW    = 16;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned VID_DEPTH = 1 << VID_AW;

    typedef enum logic [1:0] {REG_UNMAP, REG_RAM, REG_VID, REG_ROM} region_e;
    typedef enum logic {ST_IDLE, ST_PEND} state_e;

    // Boot ROM contents: fixed pattern generated from the ROM offset.
    function automatic logic [7:0] rom_byte(input logic [ROM_AW-1:0] off);
        return off[7:0] ^ off[15:8] ^ 8'hA5;
    endfunction

    logic [7:0] ram_mem  [RAM_DEPTH];
    logic [7:0] vram_mem [VID_DEPTH];

    region_e           region_c;
    logic [RAM_AW-1:0] ram_idx_c;
    logic [VID_AW-1:0] vid_off_c;
    logic [ROM_AW-1:0] rom_off_c;
    logic              cpu_vid_c;
    logic              ram_we_c;
    logic              vid_we_c;

    state_e            state_q, state_d;
    logic [VID_AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic              rom_wr_err_q, rom_wr_err_d;

    // Address decode, priority VID > ROM > RAM.
    always_comb begin
        region_c = REG_UNMAP;
        if (bus.address[19:12] == VID_BASE[19:12]) begin
            region_c = REG_VID;
        end else if (bus.address >= ROM_BASE) begin
            region_c = REG_ROM;
        end else if ((32'(bus.address) >> RAM_AW) == 32'd0) begin
            region_c = REG_RAM;
        end
        ram_idx_c = bus.address[RAM_AW-1:0];
        vid_off_c = bus.address[VID_AW-1:0];
        rom_off_c = ROM_AW'(bus.address - ROM_BASE);
        cpu_vid_c = (region_c == REG_VID);
    end

    // CPU read data and write strobes; a write returns the byte being written.
    always_comb begin
        data_d       = UNMAP;
        rom_wr_err_d = rom_wr_err_q;
        ram_we_c     = 1'b0;
        vid_we_c     = 1'b0;
        case (region_c)
            REG_RAM: begin
                ram_we_c = bus.wren;
                data_d   = bus.wren ? bus.wdata : ram_mem[ram_idx_c];
            end
            REG_VID: begin
                vid_we_c = bus.wren;
                data_d   = bus.wren ? bus.wdata : vram_mem[vid_off_c];
            end
            REG_ROM: begin
                data_d = rom_byte(rom_off_c);
                if (bus.wren) begin
                    rom_wr_err_d = 1'b1;
                end
            end
            default: data_d = UNMAP;
        endcase
    end

    // Scanner arbitration: serve when the CPU is off video RAM, otherwise park the offset.
    // The read sees the array before this edge's write, so a same-byte collision returns old data.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        vid_valid_d = 1'b0;
        vid_data_d  = vid_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.vid_req) begin
                    if (cpu_vid_c) begin
                        pend_addr_d = bus.vid_addr;
                        state_d     = ST_PEND;
                    end else begin
                        vid_valid_d = 1'b1;
                        vid_data_d  = vram_mem[bus.vid_addr];
                    end
                end
            end
            ST_PEND: begin
                if (!cpu_vid_c) begin
                    vid_valid_d = 1'b1;
                    vid_data_d  = vram_mem[pend_addr_q];
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory arrays are not touched by reset.
    always_ff @(posedge clock) begin
        if (ram_we_c) begin
            ram_mem[ram_idx_c] <= bus.wdata;
        end
        if (vid_we_c) begin
            vram_mem[vid_off_c] <= bus.wdata;
        end
    end

    // Control and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pend_addr_q  <= '0;
            data_q       <= 8'h00;
            vid_data_q   <= 8'h00;
            vid_valid_q  <= 1'b0;
            rom_wr_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            data_q       <= data_d;
            vid_data_q   <= vid_data_d;
            vid_valid_q  <= vid_valid_d;
            rom_wr_err_q <= rom_wr_err_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.vid_data   = vid_data_q;
    assign bus.vid_valid  = vid_valid_q;
    assign bus.rom_wr_err = rom_wr_err_q;
endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: directed vector table, hand-written scanner
// sequences and a randomized run against a behavioural memory/scanner model.
module tb_core_mem_responder;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    core_mem_responder_if bus();

    core_mem_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [7:0]  ram_m  [65536];
    logic [7:0]  vram_m [4096];
    logic [11:0] pend_m [$];
    logic [7:0]  m_data   = 8'h00;
    logic [7:0]  m_vdata  = 8'h00;
    logic        m_vvalid = 1'b0;
    logic        m_err    = 1'b0;

    typedef struct {
        logic [19:0] addr;
        logic [7:0]  wdata;
        logic        we;
        logic [7:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rom_ref(input logic [19:0] a);
        logic [19:0] off;
        off = a - 20'hF0000;
        return off[7:0] ^ off[15:8] ^ 8'hA5;
    endfunction

    // 0 unmapped, 1 RAM, 2 video RAM, 3 ROM
    function automatic int region_of(input logic [19:0] a);
        if (a >= 20'hB8000 && a <= 20'hB8FFF) return 2;
        if (a >= 20'hF0000) return 3;
        if (a <= 20'h0FFFF) return 1;
        return 0;
    endfunction

    // Apply one cycle of inputs, advance the model, then sample just after the clock edge.
    task automatic cycle(input logic rst, input logic [19:0] a, input logic [7:0] wd,
                         input logic we, input logic vr, input logic [11:0] va);
        int rg;
        logic [11:0] off;
        reset        = rst;
        bus.address  = a;
        bus.wdata    = wd;
        bus.wren     = we;
        bus.vid_req  = vr;
        bus.vid_addr = va;
        rg = region_of(a);
        m_vvalid = 1'b0;
        if (rst) begin
            m_data  = 8'h00;
            m_vdata = 8'h00;
            m_err   = 1'b0;
            pend_m.delete();
        end else begin
            if (vr && pend_m.size() == 0) pend_m.push_back(va);
            if (pend_m.size() != 0 && rg != 2) begin
                off      = pend_m.pop_front();
                m_vdata  = vram_m[off];
                m_vvalid = 1'b1;
            end
            case (rg)
                1: begin
                    if (we) ram_m[a[15:0]] = wd;
                    m_data = ram_m[a[15:0]];
                end
                2: begin
                    if (we) vram_m[a[11:0]] = wd;
                    m_data = vram_m[a[11:0]];
                end
                3: begin
                    m_data = rom_ref(a);
                    if (we) m_err = 1'b1;
                end
                default: m_data = 8'hFF;
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    logic [19:0] ram_pool [8];
    logic [11:0] vid_pool [8];

    initial begin
        logic        s_req;
        logic [11:0] s_addr;
        logic [19:0] ra;
        logic        rwe;
        int          sel;

        vecs[0]  = '{20'h01234, 8'h5A, 1'b1, 8'h5A, 1'b0};
        vecs[1]  = '{20'h01234, 8'h00, 1'b0, 8'h5A, 1'b0};
        vecs[2]  = '{20'h20000, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[3]  = '{20'h20000, 8'h11, 1'b1, 8'hFF, 1'b0};
        vecs[4]  = '{20'h20000, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5]  = '{20'h0FFFF, 8'h33, 1'b1, 8'h33, 1'b0};
        vecs[6]  = '{20'h0FFFF, 8'h00, 1'b0, 8'h33, 1'b0};
        vecs[7]  = '{20'hB8FFF, 8'hC7, 1'b1, 8'hC7, 1'b0};
        vecs[8]  = '{20'hB8FFF, 8'h00, 1'b0, 8'hC7, 1'b0};
        vecs[9]  = '{20'hF0010, 8'h00, 1'b0, 8'hB5, 1'b0};
        vecs[10] = '{20'hF0010, 8'h00, 1'b1, 8'hB5, 1'b1};
        vecs[11] = '{20'hF0010, 8'h00, 1'b0, 8'hB5, 1'b1};
        vecs[12] = '{20'hFFFFF, 8'h00, 1'b0, 8'hA5, 1'b1};
        vecs[13] = '{20'hB7FFF, 8'h00, 1'b0, 8'hFF, 1'b1};
        vecs[14] = '{20'h10000, 8'h00, 1'b0, 8'hFF, 1'b1};

        ram_pool = '{20'h00000, 20'h00001, 20'h01234, 20'h0FFFF,
                     20'h08000, 20'h00100, 20'h0ABCD, 20'h0FF00};
        vid_pool = '{12'h000, 12'h001, 12'h010, 12'h020,
                     12'h7FF, 12'h800, 12'hFFE, 12'hFFF};

        // Reset state
        cycle(1'b1, 20'h0, 8'h0, 1'b0, 1'b0, 12'h0);
        cycle(1'b1, 20'h0, 8'h0, 1'b0, 1'b0, 12'h0);
        chk("reset data", 32'(bus.data), 32'h00);
        chk("reset vid_data", 32'(bus.vid_data), 32'h00);
        chk("reset vid_valid", 32'(bus.vid_valid), 32'h0);
        chk("reset rom_wr_err", 32'(bus.rom_wr_err), 32'h0);

        // Directed CPU vectors
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].we, 1'b0, 12'h0);
            chk($sformatf("vec%0d data", i), 32'(bus.data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d rom_wr_err", i), 32'(bus.rom_wr_err), 32'(vecs[i].exp_err));
        end
        cycle(1'b1, 20'h0, 8'h0, 1'b0, 1'b0, 12'h0);
        chk("err cleared by reset", 32'(bus.rom_wr_err), 32'h0);

        // Scanner served while the CPU is in RAM
        cycle(1'b0, 20'hB8010, 8'hC3, 1'b1, 1'b0, 12'h0);
        cycle(1'b0, 20'h00100, 8'h42, 1'b1, 1'b0, 12'h0);
        cycle(1'b0, 20'hB8000, 8'h01, 1'b1, 1'b0, 12'h0);
        cycle(1'b0, 20'hB8020, 8'h9E, 1'b1, 1'b0, 12'h0);
        cycle(1'b0, 20'h00100, 8'h00, 1'b0, 1'b1, 12'h010);
        chk("scan direct valid", 32'(bus.vid_valid), 32'h1);
        chk("scan direct data", 32'(bus.vid_data), 32'hC3);
        chk("scan direct cpu data", 32'(bus.data), 32'h42);
        cycle(1'b0, 20'h00100, 8'h00, 1'b0, 1'b0, 12'h0);
        chk("scan direct pulse end", 32'(bus.vid_valid), 32'h0);

        // Scanner deferred by three CPU video cycles
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 20'hB8000, 8'h00, 1'b0, 1'b1, 12'h020);
            chk($sformatf("scan deferred %0d valid", k), 32'(bus.vid_valid), 32'h0);
        end
        cycle(1'b0, 20'h00100, 8'h00, 1'b0, 1'b1, 12'h020);
        chk("scan retry valid", 32'(bus.vid_valid), 32'h1);
        chk("scan retry data", 32'(bus.vid_data), 32'h9E);
        cycle(1'b0, 20'h00100, 8'h00, 1'b0, 1'b0, 12'h0);
        chk("scan retry pulse end", 32'(bus.vid_valid), 32'h0);

        // Reset while a request is pending
        cycle(1'b0, 20'hB8000, 8'h00, 1'b0, 1'b1, 12'h020);
        chk("pend before reset", 32'(bus.vid_valid), 32'h0);
        cycle(1'b1, 20'h00100, 8'h00, 1'b0, 1'b1, 12'h020);
        chk("pend reset data", 32'(bus.data), 32'h00);
        chk("pend reset vid_valid", 32'(bus.vid_valid), 32'h0);
        chk("pend reset vid_data", 32'(bus.vid_data), 32'h00);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 20'h00100, 8'h00, 1'b0, 1'b0, 12'h0);
            chk($sformatf("dropped req %0d valid", k), 32'(bus.vid_valid), 32'h0);
            chk($sformatf("ram kept %0d", k), 32'(bus.data), 32'h42);
        end

        // Initialise the random address pools
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, ram_pool[i], 8'($urandom), 1'b1, 1'b0, 12'h0);
            chk($sformatf("init ram %0d", i), 32'(bus.data), 32'(m_data));
            cycle(1'b0, 20'hB8000 | 20'(vid_pool[i]), 8'($urandom), 1'b1, 1'b0, 12'h0);
            chk($sformatf("init vid %0d", i), 32'(bus.data), 32'(m_data));
        end

        // Randomized traffic against the model
        s_req  = 1'b0;
        s_addr = 12'h0;
        for (int n = 0; n < 600; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 3)      ra = ram_pool[$urandom_range(0, 7)];
            else if (sel <= 6) ra = 20'hB8000 | 20'(vid_pool[$urandom_range(0, 7)]);
            else if (sel == 7) ra = 20'hF0000 + 20'($urandom_range(0, 65535));
            else               ra = 20'h20000 + 20'($urandom_range(0, 32'h97FFF));
            rwe = ($urandom_range(0, 3) == 0);
            if (!s_req && $urandom_range(0, 2) == 0) begin
                s_req  = 1'b1;
                s_addr = vid_pool[$urandom_range(0, 7)];
            end
            cycle(1'b0, ra, 8'($urandom), rwe, s_req, s_addr);
            chk($sformatf("rnd%0d data", n), 32'(bus.data), 32'(m_data));
            chk($sformatf("rnd%0d vid_valid", n), 32'(bus.vid_valid), 32'(m_vvalid));
            chk($sformatf("rnd%0d rom_wr_err", n), 32'(bus.rom_wr_err), 32'(m_err));
            if (m_vvalid) begin
                chk($sformatf("rnd%0d vid_data", n), 32'(bus.vid_data), 32'(m_vdata));
                s_req = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
